// File: rtl/pkg_hamming.sv
// Shared definitions for the SECDED (8,4) word layout [p0,i3,i2,i1,c2,i0,c1,c0].
package pkg_hamming;

   localparam int ANCHO_PALABRA = 8;
   localparam int ANCHO_DATOS   = 4;

   // Bit positions inside the received word
   localparam int BIT_C0 = 0;
   localparam int BIT_C1 = 1;
   localparam int BIT_I0 = 2;
   localparam int BIT_C2 = 3;
   localparam int BIT_I1 = 4;
   localparam int BIT_I2 = 5;
   localparam int BIT_I3 = 6;
   localparam int BIT_P0 = 7;

   typedef enum logic [1:0] {
      SIN_ERROR,
      ERROR_SIMPLE,
      ERROR_DOBLE
   } tipo_error_e;

   // Pull the four data bits {i3,i2,i1,i0} out of a codeword
   function automatic logic [ANCHO_DATOS-1:0] extraer_datos(input logic [ANCHO_PALABRA-1:0] palabra);
      return {palabra[BIT_I3], palabra[BIT_I2], palabra[BIT_I1], palabra[BIT_I0]};
   endfunction

endpackage

// File: rtl/modulo_detector_error.sv
// SECDED detector: Hamming syndrome over positions 1..7 plus overall parity check.
// sindrome_o is the 1-based position of a single flipped bit among bits 0..6.
module modulo_detector_error
   import pkg_hamming::*;
(
   input  logic [ANCHO_PALABRA-1:0] datos_i,
   output logic [2:0]               sindrome_o,
   output logic                     error_doble_o,
   output logic                     bit_error_o
);

   logic pg;

   assign sindrome_o[0] = datos_i[BIT_C0] ^ datos_i[BIT_I0] ^ datos_i[BIT_I1] ^ datos_i[BIT_I3];
   assign sindrome_o[1] = datos_i[BIT_C1] ^ datos_i[BIT_I0] ^ datos_i[BIT_I2] ^ datos_i[BIT_I3];
   assign sindrome_o[2] = datos_i[BIT_C2] ^ datos_i[BIT_I1] ^ datos_i[BIT_I2] ^ datos_i[BIT_I3];

   // Odd overall parity means an odd number of flips: treated as one correctable bit
   assign pg            = ^datos_i;
   assign bit_error_o   = pg;
   assign error_doble_o = (sindrome_o != 3'd0) && !pg;

endmodule

// File: rtl/modulo_corrector_error.sv
// SECDED corrector: classifies and fixes the received word, registers the result
// behind a valid/ready output stage and keeps saturating error statistics.
//
// Handshake: a word transfers in when entrada_valida && entrada_lista, and the
// result transfers out when salida_valida && salida_lista. entrada_lista is
// !salida_valida || salida_lista, so the single output register refills in the
// same cycle it drains; while stalled every output field holds its value.
module modulo_corrector_error
   import pkg_hamming::*;
#(
   parameter int ANCHO_CONT = 8
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     entrada_valida,
   output logic                     entrada_lista,
   input  logic [ANCHO_PALABRA-1:0] datos_recibidos,
   output logic                     salida_valida,
   input  logic                     salida_lista,
   output logic [ANCHO_PALABRA-1:0] palabra_corregida,
   output logic [ANCHO_DATOS-1:0]   datos_corregidos,
   output logic [2:0]               sindrome_reg,
   output logic                     error_simple,
   output logic                     error_doble,
   output logic [2:0]               posicion_error,
   input  logic                     borrar_cont,
   output logic [ANCHO_CONT-1:0]    cont_simples,
   output logic [ANCHO_CONT-1:0]    cont_dobles
);

   logic [2:0]               sindrome;
   logic                     det_doble;
   logic                     det_bit_error;
   logic                     pg_local;
   logic                     acepta;

   tipo_error_e              tipo_d;
   logic [ANCHO_PALABRA-1:0] palabra_d;
   logic [2:0]               pos_d;

   logic                     valido_q;
   logic [ANCHO_PALABRA-1:0] palabra_q;
   logic [2:0]               sindrome_q;
   logic                     simple_q;
   logic                     doble_q;
   logic [2:0]               pos_q;
   logic [ANCHO_CONT-1:0]    cont_s_q, cont_s_d;
   logic [ANCHO_CONT-1:0]    cont_d_q, cont_d_d;

   modulo_detector_error u_detector (
      .datos_i       (datos_recibidos),
      .sindrome_o    (sindrome),
      .error_doble_o (det_doble),
      .bit_error_o   (det_bit_error)
   );

   // Overall parity recomputed here; agrees with the detector's own flags
   assign pg_local = ^datos_recibidos;

   assign entrada_lista = !valido_q || salida_lista;
   assign acepta        = entrada_valida && entrada_lista;

   // Classify the incoming word and build its corrected version
   always_comb begin
      tipo_d    = SIN_ERROR;
      palabra_d = datos_recibidos;
      pos_d     = 3'd0;
      if (det_doble) begin
         tipo_d = ERROR_DOBLE;
      end else if ((sindrome != 3'd0) || pg_local) begin
         tipo_d = ERROR_SIMPLE;
         // A zero syndrome with odd parity can only be the overall parity bit
         if (det_bit_error && (sindrome == 3'd0)) begin
            pos_d = 3'(BIT_P0);
         end else begin
            pos_d = sindrome - 3'd1;
         end
         palabra_d[pos_d] = ~palabra_d[pos_d];
      end
   end

   // Next values of the statistics counters: clear wins, then saturating increment
   always_comb begin
      cont_s_d = cont_s_q;
      cont_d_d = cont_d_q;
      if (borrar_cont) begin
         cont_s_d = '0;
         cont_d_d = '0;
      end else if (acepta) begin
         if ((tipo_d == ERROR_SIMPLE) && (cont_s_q != {ANCHO_CONT{1'b1}}))
            cont_s_d = cont_s_q + ANCHO_CONT'(1);
         if ((tipo_d == ERROR_DOBLE) && (cont_d_q != {ANCHO_CONT{1'b1}}))
            cont_d_d = cont_d_q + ANCHO_CONT'(1);
      end
   end

   // Output register: load on input transfer, drop valid once consumed
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valido_q   <= 1'b0;
         palabra_q  <= '0;
         sindrome_q <= '0;
         simple_q   <= 1'b0;
         doble_q    <= 1'b0;
         pos_q      <= '0;
      end else if (acepta) begin
         valido_q   <= 1'b1;
         palabra_q  <= palabra_d;
         sindrome_q <= sindrome;
         simple_q   <= (tipo_d == ERROR_SIMPLE);
         doble_q    <= (tipo_d == ERROR_DOBLE);
         pos_q      <= pos_d;
      end else if (salida_lista) begin
         valido_q   <= 1'b0;
      end
   end

   // Statistics counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cont_s_q <= '0;
         cont_d_q <= '0;
      end else begin
         cont_s_q <= cont_s_d;
         cont_d_q <= cont_d_d;
      end
   end

   assign salida_valida     = valido_q;
   assign palabra_corregida = palabra_q;
   assign datos_corregidos  = extraer_datos(palabra_q);
   assign sindrome_reg      = sindrome_q;
   assign error_simple      = simple_q;
   assign error_doble       = doble_q;
   assign posicion_error    = pos_q;
   assign cont_simples      = cont_s_q;
   assign cont_dobles       = cont_d_q;

endmodule

// File: tb/tb_modulo_corrector_error.sv
// Directed bench for modulo_corrector_error with hand-computed expectations,
// an expected-result queue and a monitor that checks every output transfer.
module tb_modulo_corrector_error;

   localparam int ANCHO_CONT = 2;
   localparam int W = 8 + 4 + 3 + 1 + 1 + 3 + 2 * ANCHO_CONT;

   logic                  clk;
   logic                  rst_n;
   logic                  entrada_valida;
   logic                  entrada_lista;
   logic [7:0]            datos_recibidos;
   logic                  salida_valida;
   logic                  salida_lista;
   logic [7:0]            palabra_corregida;
   logic [3:0]            datos_corregidos;
   logic [2:0]            sindrome_reg;
   logic                  error_simple;
   logic                  error_doble;
   logic [2:0]            posicion_error;
   logic                  borrar_cont;
   logic [ANCHO_CONT-1:0] cont_simples;
   logic [ANCHO_CONT-1:0] cont_dobles;

   logic [W-1:0] exp_q[$];
   int n_vec  = 0;
   int n_miss = 0;

   modulo_corrector_error #(.ANCHO_CONT(ANCHO_CONT)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .entrada_valida    (entrada_valida),
      .entrada_lista     (entrada_lista),
      .datos_recibidos   (datos_recibidos),
      .salida_valida     (salida_valida),
      .salida_lista      (salida_lista),
      .palabra_corregida (palabra_corregida),
      .datos_corregidos  (datos_corregidos),
      .sindrome_reg      (sindrome_reg),
      .error_simple      (error_simple),
      .error_doble       (error_doble),
      .posicion_error    (posicion_error),
      .borrar_cont       (borrar_cont),
      .cont_simples      (cont_simples),
      .cont_dobles       (cont_dobles)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   function automatic logic [W-1:0] pack(input logic [7:0] pal, input logic [3:0] dat,
                                         input logic [2:0] s, input logic es, input logic ed,
                                         input logic [2:0] pos,
                                         input logic [ANCHO_CONT-1:0] cs,
                                         input logic [ANCHO_CONT-1:0] cd);
      return {pal, dat, s, es, ed, pos, cs, cd};
   endfunction

   task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] esp);
      n_vec++;
      if (act !== esp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nombre, act, esp, $time);
      end
   endtask

   // Driver: present one word, wait (bounded) until it is taken
   task automatic send(input logic [7:0] w, input logic [W-1:0] e, input logic borrar);
      bit ok;
      ok = 1'b0;
      exp_q.push_back(e);
      entrada_valida  = 1'b1;
      datos_recibidos = w;
      borrar_cont     = borrar;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         ok = entrada_lista;
         @(posedge clk);
      end
      #1;
      entrada_valida = 1'b0;
      borrar_cont    = 1'b0;
      if (!ok) begin
         n_vec++;
         n_miss++;
         $display("FAIL accept_timeout: word %0h got not accepted, expected accepted", w);
      end
   endtask

   // Monitor / scoreboard: compare every output transfer with the queue head
   always @(negedge clk) begin
      logic [W-1:0] act;
      logic [W-1:0] esp;
      if (salida_valida === 1'b1 && salida_lista === 1'b1) begin
         act = {palabra_corregida, datos_corregidos, sindrome_reg, error_simple,
                error_doble, posicion_error, cont_simples, cont_dobles};
         if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_output: got %0h expected no output", act);
         end else begin
            esp = exp_q.pop_front();
            chk("resultado", 32'(act), 32'(esp));
         end
      end
   end

   // Directed sequence
   initial begin
      rst_n           = 1'b0;
      entrada_valida  = 1'b0;
      datos_recibidos = 8'h00;
      salida_lista    = 1'b1;
      borrar_cont     = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_salida_valida", 32'(salida_valida), 32'd0);
      chk("rst_entrada_lista", 32'(entrada_lista), 32'd1);
      chk("rst_palabra", 32'(palabra_corregida), 32'h00);
      chk("rst_cont_simples", 32'(cont_simples), 32'd0);
      chk("rst_cont_dobles", 32'(cont_dobles), 32'd0);
      @(posedge clk); #1;

      // Clean word, then check one-cycle latency
      send(8'h55, pack(8'h55, 4'hB, 3'd0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0), 1'b0);
      @(negedge clk);
      chk("latencia", 32'(salida_valida), 32'd1);
      @(posedge clk); #1;

      // Back-to-back mix of classifications
      send(8'h45, pack(8'h55, 4'hB, 3'd5, 1'b1, 1'b0, 3'd4, 2'd1, 2'd0), 1'b0);
      send(8'hD5, pack(8'h55, 4'hB, 3'd0, 1'b1, 1'b0, 3'd7, 2'd2, 2'd0), 1'b0);
      send(8'h56, pack(8'h56, 4'hB, 3'd3, 1'b0, 1'b1, 3'd0, 2'd2, 2'd1), 1'b0);
      send(8'h54, pack(8'h55, 4'hB, 3'd1, 1'b1, 1'b0, 3'd0, 2'd3, 2'd1), 1'b0);
      send(8'h95, pack(8'h95, 4'h3, 3'd7, 1'b0, 1'b1, 3'd0, 2'd3, 2'd2), 1'b0);
      send(8'hFF, pack(8'hFF, 4'hF, 3'd0, 1'b0, 1'b0, 3'd0, 2'd3, 2'd2), 1'b0);
      send(8'hDF, pack(8'hFF, 4'hF, 3'd6, 1'b1, 1'b0, 3'd5, 2'd3, 2'd2), 1'b0);
      @(negedge clk);
      @(posedge clk); #1;

      // Backpressure: hold a result, offer another word, nothing may move
      salida_lista = 1'b0;
      send(8'h00, pack(8'h00, 4'h0, 3'd0, 1'b0, 1'b0, 3'd0, 2'd3, 2'd2), 1'b0);
      entrada_valida  = 1'b1;
      datos_recibidos = 8'h45;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_entrada_lista", 32'(entrada_lista), 32'd0);
         chk("hold_salida_valida", 32'(salida_valida), 32'd1);
         chk("hold_palabra", 32'(palabra_corregida), 32'h00);
      end
      @(posedge clk); #1;
      salida_lista = 1'b1;
      exp_q.push_back(pack(8'h55, 4'hB, 3'd5, 1'b1, 1'b0, 3'd4, 2'd3, 2'd2));
      @(negedge clk);
      chk("release_entrada_lista", 32'(entrada_lista), 32'd1);
      @(posedge clk); #1;
      entrada_valida = 1'b0;
      @(negedge clk);
      chk("release_latencia", 32'(salida_valida), 32'd1);
      chk("release_palabra", 32'(palabra_corregida), 32'h55);
      @(posedge clk); #1;

      // Counter clear on its own
      borrar_cont = 1'b1;
      @(posedge clk); #1;
      borrar_cont = 1'b0;
      @(negedge clk);
      chk("clear_cont_simples", 32'(cont_simples), 32'd0);
      chk("clear_cont_dobles", 32'(cont_dobles), 32'd0);
      @(posedge clk); #1;

      // Five single errors in a row saturate a 2-bit counter at 3
      send(8'h45, pack(8'h55, 4'hB, 3'd5, 1'b1, 1'b0, 3'd4, 2'd1, 2'd0), 1'b0);
      send(8'hD5, pack(8'h55, 4'hB, 3'd0, 1'b1, 1'b0, 3'd7, 2'd2, 2'd0), 1'b0);
      send(8'h54, pack(8'h55, 4'hB, 3'd1, 1'b1, 1'b0, 3'd0, 2'd3, 2'd0), 1'b0);
      send(8'hDF, pack(8'hFF, 4'hF, 3'd6, 1'b1, 1'b0, 3'd5, 2'd3, 2'd0), 1'b0);
      send(8'h45, pack(8'h55, 4'hB, 3'd5, 1'b1, 1'b0, 3'd4, 2'd3, 2'd0), 1'b0);
      // Clear together with a sixth single error: clear wins
      send(8'hD5, pack(8'h55, 4'hB, 3'd0, 1'b1, 1'b0, 3'd7, 2'd0, 2'd0), 1'b1);
      @(negedge clk);
      chk("clear_prioridad", 32'(cont_simples), 32'd0);
      @(posedge clk); #1;

      // Reset while a result is held
      salida_lista = 1'b0;
      send(8'h54, pack(8'h55, 4'hB, 3'd1, 1'b1, 1'b0, 3'd0, 2'd1, 2'd0), 1'b0);
      @(negedge clk);
      chk("pre_rst_cont_simples", 32'(cont_simples), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      // The held result is discarded by reset, so it is no longer expected
      exp_q.delete();
      @(negedge clk);
      chk("midrst_salida_valida", 32'(salida_valida), 32'd0);
      chk("midrst_cont_simples", 32'(cont_simples), 32'd0);
      chk("midrst_entrada_lista", 32'(entrada_lista), 32'd1);
      @(posedge clk); #1;
      rst_n        = 1'b1;
      salida_lista = 1'b1;

      // Recovery after reset
      send(8'hFF, pack(8'hFF, 4'hF, 3'd0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0), 1'b0);
      repeat (3) @(negedge clk);
      chk("cola_vacia", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/modulo_corrector_error.md
Name: modulo_corrector_error

Overview:
- Downstream stage of the SECDED error detector: accepts an 8-bit received word `[p0,i3,i2,i1,c2,i0,c1,c0]`, instantiates the detector to obtain syndrome and global parity, corrects single-bit errors, flags double errors and extracts the 4 data bits.
- The result is registered behind a valid/ready handshake so a display or UART stage can consume it.
- Saturating statistics counters record single and double errors for the 7-segment/LED front end.

Parameters:
- ANCHO_CONT, 8: width of each error-statistics counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- entrada_valida  in  1  input word present.
- entrada_lista  out  1  block can accept input.
- datos_recibidos  in  8  received word, bit7=p0, bit6=i3, bit5=i2, bit4=i1, bit3=c2, bit2=i0, bit1=c1, bit0=c0.
- salida_valida  out  1  registered result present.
- salida_lista  in  1  consumer accepts result.
- palabra_corregida  out  8  corrected 8-bit word.
- datos_corregidos  out  4  {i3,i2,i1,i0} taken from palabra_corregida.
- sindrome_reg  out  3  registered syndrome.
- error_simple  out  1  single error detected and corrected.
- error_doble  out  1  uncorrectable double error.
- posicion_error  out  3  bit index corrected, 0..7; 0 when no correction.
- borrar_cont  in  1  one-cycle clear of the statistics counters.
- cont_simples  out  ANCHO_CONT  saturating count of accepted words with error_simple.
- cont_dobles  out  ANCHO_CONT  saturating count of accepted words with error_doble.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all outputs, counters and the output register to 0. salida_valida=0 and entrada_lista=1 on the first cycle after reset. Reset mid-transfer drops the held result.
- Handshake:
  - Input transfer when entrada_valida && entrada_lista.
  - entrada_lista = !salida_valida || salida_lista, a combinational pass-through of salida_lista, so full throughput is one word per clk.
  - Output transfer when salida_valida && salida_lista.
  - While salida_valida=1 && salida_lista=0, all output fields are held stable.
- Latency: result is visible exactly 1 cycle after the input transfer.
- Classification, using detector outputs s = syndrome and pg = global parity:
  - s=0, pg=0: no error. Word passes unchanged; all flags 0.
  - s!=0, pg=1: single error at bit index s-1. Flip that bit; error_simple=1; posicion_error=s-1.
  - s=0, pg=1: single error in p0. Flip bit7; error_simple=1; posicion_error=7.
  - s!=0, pg=0: double error. Word passes uncorrected; error_doble=1; error_simple=0; posicion_error=0.
- error_simple and error_doble are never both 1.
- datos_corregidos = {palabra_corregida[6], [5], [4], [2]}.
- Counters:
  - Increment on each input transfer whose classification sets the corresponding flag.
  - Saturate at 2^ANCHO_CONT-1; no wrap-around.
  - borrar_cont=1 zeroes both counters. It has priority over a simultaneous increment, so the count is 0 afterwards.
- Back-to-back accepts with salida_lista tied high: a new result every cycle; counters increment every qualifying cycle.

Decomposition:
- Shared package `pkg_hamming`:
  - Constants: bit-index localparams for p0, i3..i0, c2..c0; ANCHO_PALABRA=8, ANCHO_DATOS=4.
  - Typedef: enum `tipo_error_e` {SIN_ERROR, ERROR_SIMPLE, ERROR_DOBLE}.
  - Function: `extraer_datos(palabra)`.
- Sub-module: the existing `modulo_detector_error`, instantiated unchanged for the syndrome. Global parity is recomputed locally as the XOR of all 8 bits, consistent with that module's error_doble/bit_error.

Test Plan:
1. Reset then clean word 8'h55 with salida_lista=1 -> next cycle: palabra_corregida=8'h55, datos_corregidos=4'hB, flags 0, posicion_error=0, counters unchanged.
2. Single error 8'h45 (bit4 flipped) -> sindrome_reg=3'd5, posicion_error=4, palabra_corregida=8'h55, datos=4'hB, error_simple=1, cont_simples=1.
3. Parity-bit error 8'hD5 -> sindrome_reg=0, posicion_error=7, palabra_corregida=8'h55, error_simple=1.
4. Double error 8'h56 (bits0,1 flipped) -> sindrome_reg=3'd3, error_doble=1, error_simple=0, palabra_corregida=8'h56, cont_dobles=1.
5. Backpressure: salida_lista=0 with a result held -> entrada_lista=0; new input not accepted; outputs stable for 5 cycles. Release -> next word accepted in the same cycle, appears the following cycle.
6. ANCHO_CONT=2, 5 consecutive single errors -> cont_simples saturates at 3. Assert borrar_cont in the same cycle as a sixth single error -> count is 0 afterwards. Drop rst_n mid-stream -> salida_valida=0 and counters 0 on the next cycle.
